// File: rtl/code_ram_arb_pkg.sv
// rtl/code_ram_arb_pkg.sv - shared types for the code RAM port arbiter
// ERR_RESPONSE exists only when CODE_RAM_ARB_RANGE_CHECK_EN is defined.
package code_ram_arb_pkg;

    localparam int TIMER_WIDTH = 8;

`ifdef CODE_RAM_ARB_RANGE_CHECK_EN
    typedef enum logic [1:0] {IDLE, WAIT_RESPONSE, DRAIN, ERR_RESPONSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_RESPONSE, DRAIN} state_t;
`endif

    typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin picker with one-hot select
module rr_arbiter_2
    import code_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last_grant,
    output logic [1:0] sel
);

    always_comb begin
        sel = req;
        if (req == 2'b11) begin
            sel = (last_grant == M1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/code_ram_port_arbiter.sv
// rtl/code_ram_port_arbiter.sv - shares the code RAM data port between two requesters
// Optional address window check: CODE_RAM_ARB_RANGE_CHECK_EN.
module code_ram_port_arbiter
    import code_ram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0001_0000,
    parameter logic [31:0] END_ADDRESS    = 32'h0001_FFFF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    master_t                owner_q, owner_d, last_grant_q, last_grant_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;

    logic [1:0]  sel;
    master_t     sel_m;
    logic        sel_we, in_range, grant;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr, sel_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    rr_arbiter_2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .sel        (sel)
    );

    assign sel_m     = sel[1] ? M1 : M0;
    assign sel_we    = (sel_m == M1) ? m1_we    : m0_we;
    assign sel_be    = (sel_m == M1) ? m1_be    : m0_be;
    assign sel_addr  = (sel_m == M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (sel_m == M1) ? m1_wdata : m0_wdata;
    assign in_range  = (sel_addr >= BASE_ADDRESS) && (sel_addr <= END_ADDRESS);

`ifndef CODE_RAM_ARB_RANGE_CHECK_EN
    logic unused_in_range;
    assign unused_in_range = in_range;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        s_req        = 1'b0;
        s_we         = 1'b0;
        s_be         = '0;
        s_addr       = '0;
        s_wdata      = '0;
        grant        = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = '0;
        case (state_q)
            IDLE: begin
                if (|sel) begin
`ifdef CODE_RAM_ARB_RANGE_CHECK_EN
                    // Out-of-window requests are absorbed locally, never reaching the RAM
                    if (!in_range) begin
                        grant        = 1'b1;
                        owner_d      = sel_m;
                        last_grant_d = sel_m;
                        state_d      = ERR_RESPONSE;
                    end else
`endif
                    begin
                        s_req   = 1'b1;
                        s_we    = sel_we;
                        s_be    = sel_be;
                        s_addr  = sel_addr;
                        s_wdata = sel_wdata;
                        if (s_gnt) begin
                            grant        = 1'b1;
                            owner_d      = sel_m;
                            last_grant_d = sel_m;
                            timer_d      = '0;
                            state_d      = WAIT_RESPONSE;
                        end
                    end
                end
            end
            WAIT_RESPONSE: begin
                if (s_rvalid) begin
                    resp_valid = 1'b1;
                    resp_rdata = s_rdata;
                    resp_err   = s_err;
                    state_d    = IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            // Swallow the late slave response; waits indefinitely for it
            DRAIN: begin
                if (s_rvalid) begin
                    state_d = IDLE;
                end
            end
`ifdef CODE_RAM_ARB_RANGE_CHECK_EN
            ERR_RESPONSE: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= M0;
            last_grant_q <= M1;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
        end
    end

    assign m0_gnt    = grant && (sel_m == M0);
    assign m1_gnt    = grant && (sel_m == M1);
    assign m0_rvalid = resp_valid && (owner_q == M0);
    assign m1_rvalid = resp_valid && (owner_q == M1);
    assign m0_rdata  = m0_rvalid ? resp_rdata : '0;
    assign m1_rdata  = m1_rvalid ? resp_rdata : '0;
    assign m0_err    = m0_rvalid && resp_err;
    assign m1_err    = m1_rvalid && resp_err;

endmodule

// File: tb/tb_code_ram_port_arbiter.sv
// tb/tb_code_ram_port_arbiter.sv - scoreboard bench for code_ram_port_arbiter
// Out-of-window case follows CODE_RAM_ARB_RANGE_CHECK_EN.
module tb_code_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    typedef struct {int cyc; logic m;} gnt_t;
    typedef struct {int cyc; logic m; logic [31:0] rdata; logic err;} resp_t;

    gnt_t  gq[$];
    resp_t rq[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    t0;

    code_ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input int c, input logic m);
        gnt_t g;
        g.cyc = c; g.m = m;
        gq.push_back(g);
    endtask

    task automatic push_resp(input int c, input logic m, input logic [31:0] d, input logic e);
        resp_t r;
        r.cyc = c; r.m = m; r.rdata = d; r.err = e;
        rq.push_back(r);
    endtask

    // Monitor: every grant and response the DUT presents must match the queue head
    always @(negedge clk) begin
        gnt_t  g;
        resp_t r;
        if (m0_gnt || m1_gnt) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {m1_gnt, m0_gnt}, 32'h0);
            end else begin
                g = gq.pop_front();
                chk("gnt_cycle", g.cyc, cyc);
                chk("gnt_owner", {m1_gnt, m0_gnt}, g.m ? 32'h2 : 32'h1);
            end
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", {m1_rvalid, m0_rvalid}, 32'h0);
            end else begin
                r = rq.pop_front();
                chk("resp_cycle", r.cyc, cyc);
                chk("resp_owner", {m1_rvalid, m0_rvalid}, r.m ? 32'h2 : 32'h1);
                chk("resp_rdata", r.m ? m1_rdata : m0_rdata, r.rdata);
                chk("resp_err", r.m ? m1_err : m0_err, r.err);
                chk("resp_other_zero", r.m ? {m0_rdata[30:0], m0_err} : {m1_rdata[30:0], m1_err}, 32'h0);
            end
        end else begin
            chk("idle_resp_zero", m0_rdata | m1_rdata | {30'h0, m1_err, m0_err}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = 0; m1_wdata = 0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 0; s_err = 0;
        next(); next();
        @(negedge clk);
        chk("reset_sreq", s_req, 0);
        chk("reset_sfields", s_addr | s_wdata | {27'h0, s_be, s_we}, 0);
        chk("reset_gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
        next();
        rst = 1'b0;
        next();

        // Backpressure: m1 alone, m0 joins in cycle 1, slave grants in cycle 3
        m1_req = 1; m1_addr = 32'h0001_0300;
        @(negedge clk);
        chk("bp_c0_sreq", s_req, 1);
        chk("bp_c0_saddr", s_addr, 32'h0001_0300);
        next();
        m0_req = 1; m0_we = 1; m0_be = 4'h3; m0_addr = 32'h0001_0400; m0_wdata = 32'h0000_55AA;
        repeat (2) begin
            @(negedge clk);
            chk("bp_saddr", s_addr, 32'h0001_0400);
            chk("bp_swe", s_we, 1);
            chk("bp_sbe", s_be, 4'h3);
            chk("bp_swdata", s_wdata, 32'h0000_55AA);
            chk("bp_no_gnt", {m0_gnt, m1_gnt}, 0);
            next();
        end
        s_gnt = 1; push_gnt(cyc, 0);
        next();
        m0_req = 0; m0_we = 0; m0_be = 4'hF; s_gnt = 0;
        s_rvalid = 1; s_rdata = 0; push_resp(cyc, 0, 0, 0);
        next();
        s_rvalid = 0; s_gnt = 1; push_gnt(cyc, 1);
        next();
        m1_req = 0; s_gnt = 0; s_rvalid = 1; s_err = 1; s_rdata = 32'h77; push_resp(cyc, 1, 32'h77, 1);
        next();
        s_rvalid = 0; s_err = 0;

        // Single read by m0
        m0_req = 1; m0_addr = 32'h0001_0040; s_gnt = 1; push_gnt(cyc, 0);
        next();
        m0_req = 0; s_gnt = 0;
        next();
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; push_resp(cyc, 0, 32'hDEAD_BEEF, 0);
        next();
        s_rvalid = 0;

        // Timeout, then drain of the late response, then normal service
        m1_req = 1; m1_addr = 32'h0001_0500; s_gnt = 1; t0 = cyc;
        push_gnt(t0, 1); push_resp(t0 + 16, 1, 0, 1);
        next();
        m1_req = 0; s_gnt = 0;
        repeat (16) next();
        m0_req = 1; m0_addr = 32'h0001_0600; s_gnt = 1;
        repeat (2) next();
        s_rvalid = 1; s_rdata = 32'h1234;
        next();
        s_rvalid = 0; push_gnt(cyc, 0);
        chk("drain_exit_cycle", cyc, t0 + 20);
        next();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h42; push_resp(cyc, 0, 32'h42, 0);
        next();
        s_rvalid = 0;

        // Reset while waiting for a response
        m0_req = 1; m0_addr = 32'h0001_0700; s_gnt = 1; push_gnt(cyc, 0);
        next();
        m0_req = 0; s_gnt = 0;
        next();
        rst = 1;
        next();
        rst = 0; s_rvalid = 1; s_rdata = 32'h0BAD;
        @(negedge clk);
        chk("rst_mid_sreq", s_req, 0);
        chk("rst_mid_rvalid", {m0_rvalid, m1_rvalid}, 0);
        next();
        s_rvalid = 0;

        // Contention: tie after reset goes to M0, then alternates
        m0_req = 1; m1_req = 1; m0_addr = 32'h0001_0100; m1_addr = 32'h0001_0200; s_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            push_gnt(cyc, k[0]);
            s_rvalid = 0;
            @(negedge clk);
            chk("cont_saddr", s_addr, k[0] ? 32'h0001_0200 : 32'h0001_0100);
            next();
            s_rvalid = 1; s_rdata = 32'hA0 + k; push_resp(cyc, k[0], 32'hA0 + k, 0);
            if (k == 3) begin
                m0_req = 0; m1_req = 0; s_gnt = 0;
            end
            next();
        end
        s_rvalid = 0;

        // Out-of-window address from m1
        m1_req = 1; m1_we = 1; m1_addr = 32'h0002_0000;
`ifdef CODE_RAM_ARB_RANGE_CHECK_EN
        s_gnt = 0; push_gnt(cyc, 1);
        @(negedge clk);
        chk("range_sreq", s_req, 0);
        next();
        m1_req = 0; m1_we = 0; push_resp(cyc, 1, 0, 1);
        next();
`else
        s_gnt = 1; push_gnt(cyc, 1);
        @(negedge clk);
        chk("range_sreq", s_req, 1);
        chk("range_saddr", s_addr, 32'h0002_0000);
        next();
        m1_req = 0; m1_we = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h99; push_resp(cyc, 1, 32'h99, 0);
        next();
        s_rvalid = 0;
`endif
        next(); next();
        chk("gnt_queue_empty", gq.size(), 0);
        chk("resp_queue_empty", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
